// File: rtl/fpu_arb_pkg.sv
// Shared constants and tag/issue records for the FP32 add/sub arbiter slice.
// Used by both the default round-robin build and the FPU_ARB_FIXED_PRIORITY_EN build.
package fpu_arb_pkg;

    localparam int FPU_DATA_W   = 32;
    localparam int FPU_LAT_DEF  = 3;
    localparam int FPU_ID_MAX_W = 3;

    // Tag id is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                    valid;
        logic [FPU_ID_MAX_W-1:0] id;
    } fpu_tag_t;

    typedef struct packed {
        logic                  valid;
        logic [FPU_DATA_W-1:0] a;
        logic [FPU_DATA_W-1:0] b;
        logic                  sub;
    } fpu_issue_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// One-hot arbiter over N_REQ requests; round-robin from ptr_i by default.
// With FPU_ARB_FIXED_PRIORITY_EN defined it is a plain lowest-index priority encoder.
module fpu_rr_arbiter
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
`ifndef FPU_ARB_FIXED_PRIORITY_EN
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  ptr_next_o,
`endif
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_valid_o
);

`ifdef FPU_ARB_FIXED_PRIORITY_EN
    // Scanning downward lets the lowest valid index make the final assignment.
    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (en_i && req_i[i]) begin
                gnt_o       = '0;
                gnt_o[i]    = 1'b1;
                gnt_id_o    = ID_W'(i);
                gnt_valid_o = 1'b1;
            end
        end
    end
`else
    // Scanning offsets downward leaves the nearest valid requester at/after ptr_i as winner.
    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (en_i && req_i[(int'(ptr_i) + i) % N_REQ]) begin
                gnt_o                              = '0;
                gnt_o[(int'(ptr_i) + i) % N_REQ]   = 1'b1;
                gnt_id_o                           = ID_W'((int'(ptr_i) + i) % N_REQ);
                gnt_valid_o                        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next_o = ptr_i;
        if (gnt_valid_o) begin
            ptr_next_o = (gnt_id_o == ID_W'(N_REQ - 1)) ? '0 : gnt_id_o + ID_W'(1);
        end
    end
`endif

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one fixed-latency FP32 add/sub unit among N_REQ requesters and returns tagged results.
// Define FPU_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = FPU_DATA_W,
    parameter int FPU_LAT = FPU_LAT_DEF,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [N_REQ-1:0][DATA_W-1:0] i_req_a,
    input  logic [N_REQ-1:0][DATA_W-1:0] i_req_b,
    input  logic [N_REQ-1:0]             i_req_sub,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic                         o_fpu_valid,
    output logic [DATA_W-1:0]            o_fpu_a,
    output logic [DATA_W-1:0]            o_fpu_b,
    output logic                         o_fpu_sub,
    input  logic [DATA_W-1:0]            i_fpu_result,
    output logic                         o_rsp_valid,
    output logic [ID_W-1:0]              o_rsp_id,
    output logic [DATA_W-1:0]            o_rsp_data,
    output logic                         o_busy
);

    logic [N_REQ-1:0]       gnt;
    logic [ID_W-1:0]        gntId;
    logic                   gntValid;
    logic                   arbEn;
    fpu_issue_t             issue_q;
    fpu_issue_t             issue_d;
    logic [ID_W-1:0]        issueId_q;
    fpu_tag_t [FPU_LAT-1:0] tag_q;
    fpu_tag_t               tagLast;
    logic                   tagAny;
    logic                   rspFire;
    logic                   rspValid_q;
    logic [ID_W-1:0]        rspId_q;
    logic [DATA_W-1:0]      rspData_q;

    assign arbEn = ~i_rst & ~i_flush;

`ifdef FPU_ARB_FIXED_PRIORITY_EN
    fpu_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) uArb (
        .req_i       (i_req_valid),
        .en_i        (arbEn),
        .gnt_o       (gnt),
        .gnt_id_o    (gntId),
        .gnt_valid_o (gntValid)
    );
`else
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    fpu_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) uArb (
        .req_i       (i_req_valid),
        .en_i        (arbEn),
        .ptr_i       (ptr_q),
        .ptr_next_o  (ptr_d),
        .gnt_o       (gnt),
        .gnt_id_o    (gntId),
        .gnt_valid_o (gntValid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Operand registers hold their last value when nothing is granted.
    always_comb begin
        issue_d       = issue_q;
        issue_d.valid = gntValid;
        if (gntValid) begin
            issue_d.a   = FPU_DATA_W'(i_req_a[gntId]);
            issue_d.b   = FPU_DATA_W'(i_req_b[gntId]);
            issue_d.sub = i_req_sub[gntId];
        end
    end

    assign tagLast = tag_q[FPU_LAT-1];

    always_comb begin
        tagAny = 1'b0;
        for (int s = 0; s < FPU_LAT; s++) tagAny = tagAny | tag_q[s].valid;
    end

    // Out-of-range ids can only come from corruption; never route them back to a requester.
    assign rspFire = tagLast.valid & ~i_flush & (int'(tagLast.id) < N_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issue_q    <= '0;
            issueId_q  <= '0;
            tag_q      <= '0;
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
            rspData_q  <= '0;
        end else begin
            issue_q        <= issue_d;
            issueId_q      <= gntId;
            tag_q[0].valid <= issue_q.valid & ~i_flush;
            tag_q[0].id    <= FPU_ID_MAX_W'(issueId_q);
            for (int s = 1; s < FPU_LAT; s++) begin
                tag_q[s].valid <= tag_q[s-1].valid & ~i_flush;
                tag_q[s].id    <= tag_q[s-1].id;
            end
            rspValid_q <= rspFire;
            if (rspFire) begin
                rspId_q   <= ID_W'(tagLast.id);
                rspData_q <= i_fpu_result;
            end
        end
    end

    assign o_req_ready = gnt;
    assign o_fpu_valid = issue_q.valid;
    assign o_fpu_a     = DATA_W'(issue_q.a);
    assign o_fpu_b     = DATA_W'(issue_q.b);
    assign o_fpu_sub   = issue_q.sub;
    assign o_rsp_valid = rspValid_q;
    assign o_rsp_id    = rspId_q;
    assign o_rsp_data  = rspData_q;
    assign o_busy      = issue_q.valid | tagAny;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Scoreboard bench for fpu_addsub_arbiter with a stub FPU returning hand-computed sums.
// Covers FPU_ARB_FIXED_PRIORITY_EN as well when the macro is defined for the build.
module tb_fpu_addsub_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 32;
    localparam int FPU_LAT = 3;
    localparam int ID_W    = 2;

    logic                         i_clk;
    logic                         i_rst;
    logic                         i_flush;
    logic [N_REQ-1:0]             i_req_valid;
    logic [N_REQ-1:0][DATA_W-1:0] i_req_a;
    logic [N_REQ-1:0][DATA_W-1:0] i_req_b;
    logic [N_REQ-1:0]             i_req_sub;
    logic [N_REQ-1:0]             o_req_ready;
    logic                         o_fpu_valid;
    logic [DATA_W-1:0]            o_fpu_a;
    logic [DATA_W-1:0]            o_fpu_b;
    logic                         o_fpu_sub;
    logic [DATA_W-1:0]            i_fpu_result;
    logic                         o_rsp_valid;
    logic [ID_W-1:0]              o_rsp_id;
    logic [DATA_W-1:0]            o_rsp_data;
    logic                         o_busy;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc    = 0;
    logic [31:0] fpuSlot [16];
    logic [31:0] rrData  [4];

    fpu_addsub_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .FPU_LAT (FPU_LAT),
        .ID_W    (ID_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_req_valid  (i_req_valid),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .i_req_sub    (i_req_sub),
        .o_req_ready  (o_req_ready),
        .o_fpu_valid  (o_fpu_valid),
        .o_fpu_a      (o_fpu_a),
        .o_fpu_b      (o_fpu_b),
        .o_fpu_sub    (o_fpu_sub),
        .i_fpu_result (i_fpu_result),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_data   (o_rsp_data),
        .o_busy       (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Stub FPU: only the operand pairs used below are known; anything else returns a NaN marker.
    function automatic logic [31:0] fpuStub(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if ( sub && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (!sub && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (!sub && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if ( sub && a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
        if (!sub && a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000;
        return 32'h7FC00000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
        i_req_a[k]   = a;
        i_req_b[k]   = b;
        i_req_sub[k] = sub;
    endtask

    task automatic pushExp(input int id, input logic [31:0] data);
        expQ.push_back('{id: id, data: data, cyc: cyc + FPU_LAT + 2});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fpu_valid"}, 32'(o_fpu_valid), 32'h0);
        checkOutput({tag, "_fpu_a"},     o_fpu_a,          32'h0);
        checkOutput({tag, "_fpu_b"},     o_fpu_b,          32'h0);
        checkOutput({tag, "_fpu_sub"},   32'(o_fpu_sub),   32'h0);
        checkOutput({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'h0);
        checkOutput({tag, "_rsp_id"},    32'(o_rsp_id),    32'h0);
        checkOutput({tag, "_rsp_data"},  o_rsp_data,       32'h0);
        checkOutput({tag, "_busy"},      32'(o_busy),      32'h0);
    endtask

    // FPU model: result for an issue seen in cycle c is presented throughout cycle c+FPU_LAT.
    always @(negedge i_clk) begin
        i_fpu_result         = fpuSlot[cyc % 16];
        fpuSlot[cyc % 16]    = 32'hDEADBEEF;
        if (o_fpu_valid) fpuSlot[(cyc + FPU_LAT) % 16] = fpuStub(o_fpu_a, o_fpu_b, o_fpu_sub);
    end

    // Monitor: every response must match the oldest expectation in id, data and cycle.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_rsp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL rsp_unexpected: got id %0d data %h, expected no response", o_rsp_id, o_rsp_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_id",    32'(o_rsp_id), 32'(e.id));
                checkOutput("rsp_data",  o_rsp_data,    e.data);
                checkOutput("rsp_cycle", 32'(cyc),      32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) fpuSlot[i] = 32'hDEADBEEF;
        rrData[0] = 32'h40000000;
        rrData[1] = 32'h40800000;
        rrData[2] = 32'h40000000;
        rrData[3] = 32'h40800000;
        i_fpu_result = '0;
        i_rst        = 1'b1;
        i_flush      = 1'b0;
        i_req_valid  = '0;
        i_req_a      = '0;
        i_req_b      = '0;
        i_req_sub    = '0;

        repeat (3) @(negedge i_clk);
        checkOutput("reset_ready", 32'(o_req_ready), 32'h0);
        checkAllZero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Single add from requester 2: 1.0 + 2.0 = 3.0
        applyStimulus(2, 32'h3F800000, 32'h40000000, 1'b0);
        i_req_valid = 4'b0100;
        #1 checkOutput("add_ready", 32'(o_req_ready), 32'h4);
        pushExp(2, 32'h40400000);
        @(negedge i_clk);
        i_req_valid = '0;
        checkOutput("add_fpu_valid", 32'(o_fpu_valid), 32'h1);
        checkOutput("add_fpu_a",     o_fpu_a,          32'h3F800000);
        checkOutput("add_fpu_b",     o_fpu_b,          32'h40000000);
        checkOutput("add_fpu_sub",   32'(o_fpu_sub),   32'h0);
        checkOutput("add_busy",      32'(o_busy),      32'h1);
        repeat (6) @(negedge i_clk);

        // Subtract from requester 1: 3.0 - 1.0 = 2.0
        applyStimulus(1, 32'h40400000, 32'h3F800000, 1'b1);
        i_req_valid = 4'b0010;
        #1 checkOutput("sub_ready", 32'(o_req_ready), 32'h2);
        pushExp(1, 32'h40000000);
        @(negedge i_clk);
        i_req_valid = '0;
        checkOutput("sub_fpu_valid", 32'(o_fpu_valid), 32'h1);
        checkOutput("sub_fpu_sub",   32'(o_fpu_sub),   32'h1);
        repeat (6) @(negedge i_clk);

        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        applyStimulus(0, 32'h3F800000, 32'h3F800000, 1'b0);
        applyStimulus(1, 32'h40000000, 32'h40000000, 1'b0);
        applyStimulus(2, 32'h40800000, 32'h40000000, 1'b1);
        applyStimulus(3, 32'h40400000, 32'h3F800000, 1'b0);
`ifndef FPU_ARB_FIXED_PRIORITY_EN
        i_req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 checkOutput("rr_ready", 32'(o_req_ready), 32'(1 << (k % 4)));
            pushExp(k % 4, rrData[k % 4]);
            @(negedge i_clk);
        end
`else
        i_req_valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            #1 checkOutput("fixed_ready", 32'(o_req_ready), 32'h1);
            pushExp(0, rrData[0]);
            @(negedge i_clk);
        end
`endif
        i_req_valid = '0;
        repeat (8) @(negedge i_clk);

        // Flush: three issues, flush two cycles after the last, requester 3 waiting through it
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        i_req_valid = 4'b0010;
        @(negedge i_clk);
        i_req_valid = 4'b0100;
        @(negedge i_clk);
        i_req_valid = '0;
        @(negedge i_clk);
        i_flush     = 1'b1;
        i_req_valid = 4'b1000;
        #1 checkOutput("flush_ready", 32'(o_req_ready), 32'h0);
        @(negedge i_clk);
        i_flush = 1'b0;
        checkOutput("flush_busy",      32'(o_busy),      32'h0);
        checkOutput("flush_fpu_valid", 32'(o_fpu_valid), 32'h0);
        #1 checkOutput("post_flush_ready", 32'(o_req_ready), 32'h8);
        pushExp(3, 32'h40800000);
        @(negedge i_clk);
        i_req_valid = '0;
        repeat (8) @(negedge i_clk);

        // Reset with three operations in flight, one of them due to respond next cycle
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        i_req_valid = 4'b0010;
        @(negedge i_clk);
        i_req_valid = 4'b0100;
        @(negedge i_clk);
        i_req_valid = '0;
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_req_valid = 4'b1001;
        #1 checkOutput("midrst_ready", 32'(o_req_ready), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        checkAllZero("midrst");
        #1 checkOutput("midrst_next_grant", 32'(o_req_ready), 32'h1);
        pushExp(0, 32'h40000000);
        @(negedge i_clk);
        i_req_valid = '0;
        repeat (8) @(negedge i_clk);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
# fpu_addsub_arbiter

Shares one fully pipelined FP32 add/sub unit between `N_REQ` requesters, such as the butterfly stages of the 8-point FFT. Each cycle, a round-robin arbiter grants at most one requester and issues its operands to the shared unit. The block tracks the requester ID through the unit's fixed latency and routes each result back as a tagged response. Inside the FFT datapath it sits between the butterfly controllers and the single FPU_ADD_SUB instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: operand and result width (IEEE-754 single).
- `FPU_LAT`, 3: fixed cycles from `o_fpu_valid` to the matching `i_fpu_result` (1..8).
- `ID_W`, $clog2(N_REQ): requester ID width.

Ports:
- `i_clk`  in  1  clock; rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_flush`  in  1  discard every in-flight operation.
- `i_req_valid`  in  N_REQ  per-requester operation request.
- `i_req_a`  in  N_REQ x DATA_W  operand A per requester.
- `i_req_b`  in  N_REQ x DATA_W  operand B per requester.
- `i_req_sub`  in  N_REQ  1 = A-B, 0 = A+B.
- `o_req_ready`  out  N_REQ  one-hot grant; a transfer happens when valid & ready.
- `o_fpu_valid`  out  1  operands presented to the shared unit.
- `o_fpu_a`, `o_fpu_b`  out  DATA_W  operands to the unit.
- `o_fpu_sub`  out  1  operation select to the unit.
- `i_fpu_result`  in  DATA_W  result, sampled FPU_LAT cycles after issue.
- `o_rsp_valid`  out  1  response strobe (no backpressure).
- `o_rsp_id`  out  ID_W  requester that owns the response.
- `o_rsp_data`  out  DATA_W  result.
- `o_busy`  out  1  at least one operation is in flight.

## Operation
- **Grant.** `o_req_ready` is combinational from `i_req_valid` and the RR pointer `ptr`. The grant goes to the first valid requester at or after `ptr`, scanning upward and wrapping from N_REQ-1 to 0.
- **Grant suppression.** There is no grant while `i_flush` or `i_rst` is high.
- **Pointer update.** After a grant to k, `ptr` becomes (k+1) mod N_REQ. With no grant, `ptr` holds.
- **Requester rule.** Requesters hold a, b and sub stable while valid is high. `i_req_valid` must not depend on `o_req_ready`.
- **Issue stage (registered).** `o_fpu_valid`, `o_fpu_a`, `o_fpu_b` and `o_fpu_sub` are loaded from the granted requester. `o_fpu_valid` is 0 when there is no grant. Data outputs keep their last value when `o_fpu_valid` is 0.
- **Tag pipeline.** A shift register of depth FPU_LAT carries {valid, id}, advancing every cycle. Stage 0 is loaded from the issue stage.
- **Response.** When the last tag stage is valid, the next cycle drives `o_rsp_valid`=1, `o_rsp_id`=tag id and `o_rsp_data`=`i_fpu_result`.
- **Flush.** `i_flush` clears the issue-stage valid and all tag valids. Results already in the unit are dropped, and no response is produced for them. `ptr` is unchanged.
- **Busy.** `o_busy` = issue valid OR any tag valid.
- **No arithmetic.** The block performs no arithmetic and passes operands bit-exact.

## Timing
- Reset values: `ptr`=0, every tag valid=0, `o_fpu_valid`=0, `o_fpu_a`/`o_fpu_b`=0, `o_fpu_sub`=0, `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_data`=0, `o_busy`=0, `o_req_ready`=0.
- **Handshake to issue.** The handshake happens in cycle T. `o_fpu_valid`=1 in T+1.
- **Result capture.** `i_fpu_result` is captured at T+1+FPU_LAT.
- **Response.** `o_rsp_valid` in T+2+FPU_LAT, giving a total latency of FPU_LAT+2 (5 at the default).
- **Throughput.** One issue per cycle and one response per cycle. Responses leave in issue order.
- **Flush vs. request.** Flush and request in the same cycle: flush wins, there is no grant, and the request stays pending.
- **Reset mid-operation.** Equivalent to flush plus `ptr`=0. A response scheduled for the next cycle is suppressed.
- **Single requester.** A single requester held continuously valid is granted every cycle.

## Configuration
- Macro: `FPU_ARB_FIXED_PRIORITY_EN`.
- **Defined.** Fixed priority: the lowest-index valid requester always wins. `ptr` is neither implemented nor updated.
- **Undefined (default).** Round-robin, as described in Operation.
- Latency, flush and response behaviour are identical in both builds.

## Structure
- **Package `fpu_arb_pkg`:**
  - default `DATA_W` and `FPU_LAT` constants;
  - `fpu_tag_t` struct {valid, id};
  - `fpu_issue_t` struct {valid, a, b, sub}.
- **Sub-module `fpu_rr_arbiter`:** N_REQ-wide request vector and pointer in, one-hot grant and next pointer out. In the fixed-priority build it reduces to a priority encoder.
- **Top level:** issue register, tag shift register and response register.

## Test plan
- **Single add.** With FPU_LAT=3, requester 2 presents a=0x3F800000, b=0x40000000, add in cycle 0.
  - Cycle 1: `o_fpu_valid`=1.
  - Cycle 5: `o_rsp_valid`=1, id=2, data=0x40400000.
- **Subtract.** Requester 1 presents 0x40400000 - 0x3F800000, sub=1. Response at +5: id=1, data=0x40000000, `o_fpu_sub`=1 at issue.
- **Round-robin fairness.** All four requesters continuously valid from reset. Grants go 0,1,2,3,0,1,...; response ids follow the same order, one per cycle.
- **Flush.** Issue three operations, then assert `i_flush` two cycles later.
  - No response appears for any of them.
  - `o_busy` is 0 the cycle after flush.
  - A request held during flush is granted the next cycle.
- **Reset mid-operation.** Assert `i_rst` while 3 operations are in flight. All outputs are 0 the following cycle, and the next grant goes to requester 0.
- **Fixed-priority build.** With `FPU_ARB_FIXED_PRIORITY_EN`, requesters 0 and 3 are continuously valid. Requester 0 is granted every cycle and requester 3 is never granted.
